// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Board defaults assume a 100 MHz system clock and a 500 Hz digit slot rate.
package seg_scan_ctrl_pkg;

  localparam int unsigned CLK_HZ_DEFAULT   = 100_000_000;
  localparam int unsigned SLOT_HZ_DEFAULT  = 500;
  localparam int unsigned TICK_DIV_DEFAULT = CLK_HZ_DEFAULT / SLOT_HZ_DEFAULT;

  localparam bit ANODE_ACTIVE_LOW_DEFAULT = 1'b1;

  // Bits needed to index 0..value-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = (value > 0) ? value - 1 : 0;
    w = 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Digit-slot timer: counts enabled clocks and flags the last clock of each
// DIV-clock slot. The count holds while en is low so a pause resumes mid-slot.
module tick_gen
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned      CNT_W    = clog2(DIV);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_gen: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == TERMINAL);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: rotating digit select, per-digit
// masking, anode dead-time blanking, scan pause and a frame-start pulse.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV         = TICK_DIV_DEFAULT,
  parameter int unsigned NUM_DIGITS       = 8,
  parameter int unsigned BLANK_CYCLES     = 16,
  parameter bit          ANODE_ACTIVE_LOW = ANODE_ACTIVE_LOW_DEFAULT,
  localparam int unsigned CNT_W           = clog2(TICK_DIV),
  localparam int unsigned SEL_W           = clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic                  tick,
  output logic                  frame,
  output logic [SEL_W-1:0]      sel,
  output logic                  blanking,
  output logic [NUM_DIGITS-1:0] anode
);

  if (TICK_DIV < 2 || NUM_DIGITS < 2 || BLANK_CYCLES >= TICK_DIV) begin : g_bad_params
    $error("seg_scan_ctrl: need TICK_DIV>=2, NUM_DIGITS>=2, BLANK_CYCLES<TICK_DIV");
  end

  localparam logic [SEL_W-1:0]      LAST_SEL   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      BLANK_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] INACTIVE   = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      sel_d;
  logic [CNT_W-1:0]      bcnt_q;
  logic [CNT_W-1:0]      bcnt_d;
  logic [NUM_DIGITS-1:0] anode_q;
  logic [NUM_DIGITS-1:0] anode_d;
  logic [NUM_DIGITS-1:0] lit;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  assign frame    = tick && (sel_q == LAST_SEL);
  assign sel      = sel_q;
  assign blanking = (bcnt_q != '0);
  assign anode    = anode_q;

  always_comb begin
    sel_d  = sel_q;
    bcnt_d = bcnt_q;
    lit    = '0;

    if (en) begin
      if (tick) begin
        sel_d  = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
        bcnt_d = BLANK_LOAD;
      end else if (bcnt_q != '0) begin
        bcnt_d = bcnt_q - 1'b1;
      end
    end

    // Anode follows pre-edge sel, so with zero dead time the old digit
    // stays lit for one clock after sel moves on.
    if (en && (bcnt_q == '0) && digit_en[sel_q]) begin
      lit[sel_q] = 1'b1;
    end

    anode_d = lit ^ INACTIVE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= '0;
      bcnt_q  <= BLANK_LOAD;
      anode_q <= INACTIVE;
    end else begin
      sel_q   <= sel_d;
      bcnt_q  <= bcnt_d;
      anode_q <= anode_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: three configurations run in lockstep
// against a cycle model, plus scenario checks on timing and masking.
module tb_seg_scan_ctrl;

  localparam int NCFG = 3;
  localparam int TD [NCFG] = '{4, 4, 3};
  localparam int ND [NCFG] = '{4, 4, 6};
  localparam int BC [NCFG] = '{1, 0, 1};
  localparam int POL[NCFG] = '{1, 1, 0};

  typedef struct packed {
    logic        tick;
    logic        frame;
    logic        blanking;
    logic [3:0]  sel;
    logic [15:0] anode;
  } obs_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b1;
  logic [5:0] de    = '1;

  logic       t0, f0, b0, t1, f1, b1, t2, f2, b2;
  logic [1:0] s0, s1;
  logic [2:0] s2;
  logic [3:0] a0, a1;
  logic [5:0] a2;

  int checks = 0;
  int errors = 0;

  int          m_cnt [NCFG];
  int          m_sel [NCFG];
  int          m_bcnt[NCFG];
  logic [15:0] m_vec [NCFG];
  obs_t        sbq[$];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.TICK_DIV(4), .NUM_DIGITS(4), .BLANK_CYCLES(1), .ANODE_ACTIVE_LOW(1)) u0 (
    .clk(clk), .reset(reset), .en(en), .digit_en(de[3:0]),
    .tick(t0), .frame(f0), .sel(s0), .blanking(b0), .anode(a0));

  seg_scan_ctrl #(.TICK_DIV(4), .NUM_DIGITS(4), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .digit_en(de[3:0]),
    .tick(t1), .frame(f1), .sel(s1), .blanking(b1), .anode(a1));

  seg_scan_ctrl #(.TICK_DIV(3), .NUM_DIGITS(6), .BLANK_CYCLES(1), .ANODE_ACTIVE_LOW(0)) u2 (
    .clk(clk), .reset(reset), .en(en), .digit_en(de),
    .tick(t2), .frame(f2), .sel(s2), .blanking(b2), .anode(a2));

  function automatic logic [15:0] inactive_of(int k);
    logic [15:0] mask;
    mask = 16'((32'd1 << ND[k]) - 1);
    return (POL[k] != 0) ? mask : 16'h0;
  endfunction

  function automatic obs_t observed(int k);
    obs_t o;
    case (k)
      0:       o = '{tick: t0, frame: f0, blanking: b0, sel: 4'(s0), anode: 16'(a0)};
      1:       o = '{tick: t1, frame: f1, blanking: b1, sel: 4'(s1), anode: 16'(a1)};
      default: o = '{tick: t2, frame: f2, blanking: b2, sel: 4'(s2), anode: 16'(a2)};
    endcase
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      m_cnt[k]  = 0;
      m_sel[k]  = 0;
      m_bcnt[k] = BC[k];
      m_vec[k]  = '0;
    end
  endtask

  // Advance model k by one edge and return what the outputs should read after it.
  task automatic model_step(input int k, output obs_t e);
    logic [15:0] vec;
    logic        tk;
    vec = '0;
    if (en && m_bcnt[k] == 0 && de[m_sel[k]]) vec[m_sel[k]] = 1'b1;
    m_vec[k] = vec;
    if (en) begin
      if (m_cnt[k] == TD[k] - 1) begin
        m_cnt[k]  = 0;
        m_sel[k]  = (m_sel[k] == ND[k] - 1) ? 0 : m_sel[k] + 1;
        m_bcnt[k] = BC[k];
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_bcnt[k] > 0) m_bcnt[k] = m_bcnt[k] - 1;
      end
    end
    tk         = en && (m_cnt[k] == TD[k] - 1);
    e.tick     = tk;
    e.frame    = tk && (m_sel[k] == ND[k] - 1);
    e.blanking = (m_bcnt[k] != 0);
    e.sel      = 4'(m_sel[k]);
    e.anode    = m_vec[k] ^ inactive_of(k);
  endtask

  // One clock: push model predictions, clock, then pop and compare every DUT.
  task automatic cycle();
    obs_t e;
    obs_t o;
    for (int k = 0; k < NCFG; k++) begin
      model_step(k, e);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) begin
      e = sbq.pop_front();
      o = observed(k);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_u%0d t=%0t got tick=%b frame=%b blank=%b sel=%0d anode=%h expected tick=%b frame=%b blank=%b sel=%0d anode=%h",
                 k, $time, o.tick, o.frame, o.blanking, o.sel, o.anode,
                 e.tick, e.frame, e.blanking, e.sel, e.anode);
      end
    end
  endtask

  task automatic test_reset();
    int first_tick;
    int first_lit;
    checks++;
    if ({a0, s0, t0, b0} !== {4'b1111, 2'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_u0 got anode=%b sel=%0d tick=%b blank=%b expected 1111 0 0 1", a0, s0, t0, b0);
    end
    checks++;
    if ({b1, a2} !== {1'b0, 6'b000000}) begin
      errors++;
      $display("FAIL reset_u1u2 got blank1=%b anode2=%b expected 0 000000", b1, a2);
    end
    reset = 1'b0;
    first_tick = -1;
    first_lit  = -1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (t0 && first_tick < 0) first_tick = i;
      if (a0 == 4'b1110 && first_lit < 0) first_lit = i;
    end
    checks++;
    if (first_lit !== 2) begin
      errors++;
      $display("FAIL first_anode edge got %0d expected 2", first_lit);
    end
    checks++;
    if (first_tick !== 3) begin
      errors++;
      $display("FAIL first_tick edge got %0d expected 3", first_tick);
    end
    repeat (2) cycle();
    reset = 1'b1;
    #1;
    checks++;
    if ({a0, s0, t0} !== {4'b1111, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got anode=%b sel=%0d tick=%b expected 1111 0 0", a0, s0, t0);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_rotation();
    int ticks, frames, last_tick, bad_gap, bad_frame;
    int sel_at_tick[5];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    ticks = 0; frames = 0; last_tick = -1; bad_gap = 0; bad_frame = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (t0) begin
        if (ticks < 5) sel_at_tick[ticks] = int'(s0);
        if (last_tick >= 0 && i - last_tick != 4) bad_gap++;
        last_tick = i;
        ticks++;
      end
      if (f0) begin
        frames++;
        if (s0 != 2'd3 || !t0) bad_frame++;
      end
    end
    checks++;
    if (ticks != 5 || bad_gap != 0) begin
      errors++;
      $display("FAIL rotation_ticks got count=%0d bad_gaps=%0d expected 5 0", ticks, bad_gap);
    end
    checks++;
    if (frames != 1 || bad_frame != 0) begin
      errors++;
      $display("FAIL rotation_frame got count=%0d misplaced=%0d expected 1 0", frames, bad_frame);
    end
    checks++;
    if (ticks < 5 || sel_at_tick != exp_seq) begin
      errors++;
      $display("FAIL rotation_seq got %0d %0d %0d %0d %0d expected 0 1 2 3 0", sel_at_tick[0],
               sel_at_tick[1], sel_at_tick[2], sel_at_tick[3], sel_at_tick[4]);
    end
  endtask

  task automatic test_dead_time();
    int dark0, blank0, dark1, run, max_run;
    dark0 = 0; blank0 = 0; dark1 = 0; run = 0; max_run = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (a0 == 4'b1111) begin
        dark0++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (b0) blank0++;
      if (a1 == 4'b1111) dark1++;
    end
    checks++;
    if (dark0 != 6 || max_run != 1 || blank0 != 6) begin
      errors++;
      $display("FAIL dead_time_b1 got dark=%0d longest=%0d blank=%0d expected 6 1 6", dark0, max_run, blank0);
    end
    checks++;
    if (dark1 != 0) begin
      errors++;
      $display("FAIL dead_time_b0 got dark=%0d expected 0", dark1);
    end
  endtask

  task automatic test_mask();
    int d0, d2, masked, ticks;
    d0 = 0; d2 = 0; masked = 0; ticks = 0;
    de = 6'b000101;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (a0 == 4'b1110) d0++;
      if (a0 == 4'b1011) d2++;
      if (a0 == 4'b1101 || a0 == 4'b0111) masked++;
      if (t0) ticks++;
    end
    checks++;
    if (masked != 0 || d0 == 0 || d2 == 0) begin
      errors++;
      $display("FAIL mask_anode got masked_lit=%0d d0=%0d d2=%0d expected 0 >0 >0", masked, d0, d2);
    end
    checks++;
    if (ticks != 4) begin
      errors++;
      $display("FAIL mask_tick_rate got %0d expected 4", ticks);
    end
    de = '1;
  endtask

  task automatic test_pause();
    int guard, ticks, lit, moved, wait_edges;
    guard = 0;
    while (!(m_cnt[0] == 2 && m_sel[0] == 1) && guard < 40) begin
      cycle();
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL pause_setup got no cnt=2 sel=1 within %0d cycles expected reachable", guard);
    end
    en = 1'b0;
    ticks = 0; lit = 0; moved = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (t0) ticks++;
      if (a0 != 4'b1111) lit++;
      if (s0 != 2'd1) moved++;
    end
    checks++;
    if (ticks != 0 || lit != 0 || moved != 0) begin
      errors++;
      $display("FAIL pause_hold got ticks=%0d lit=%0d sel_moved=%0d expected 0 0 0", ticks, lit, moved);
    end
    en = 1'b1;
    wait_edges = 0;
    while (!t0 && wait_edges < 10) begin
      cycle();
      wait_edges++;
    end
    checks++;
    if (wait_edges != TD[0] - 1 - 2) begin
      errors++;
      $display("FAIL pause_resume got %0d edges to tick expected %0d", wait_edges, TD[0] - 3);
    end
  endtask

  task automatic test_non_pow2();
    int max_sel, frames, last, bad_gap;
    max_sel = 0; frames = 0; last = -1; bad_gap = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (int'(s2) > max_sel) max_sel = int'(s2);
      if (f2) begin
        if (last >= 0 && i - last != 18) bad_gap++;
        last = i;
        frames++;
      end
    end
    checks++;
    if (max_sel != 5) begin
      errors++;
      $display("FAIL np2_sel_max got %0d expected 5", max_sel);
    end
    checks++;
    if (frames < 3 || bad_gap != 0) begin
      errors++;
      $display("FAIL np2_frame got count=%0d bad_gaps=%0d expected >=3 0", frames, bad_gap);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(3) != 0);
      de = 6'($urandom_range(63));
      cycle();
    end
    en = 1'b1;
    de = '1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d left expected 0", sbq.size());
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rotation();
    test_dead_time();
    test_mask();
    test_pause();
    test_non_pow2();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
